// File: rtl/icache_pkg.sv
// Shared constants for the direct-mapped instruction cache: default geometry
// and the refill FSM encodings.
package icache_pkg;

    localparam int ICACHE_INDEX_BITS  = 6;
    localparam int ICACHE_OFFSET_BITS = 2;

    typedef enum logic {
        ICACHE_IDLE   = 1'b0,
        ICACHE_REFILL = 1'b1
    } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side bus of the instruction cache. The cache is the
// slave on this bundle; the fetch stage and memory controller form the master.
interface icache_if;

    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        hit;
    logic [31:0] hit_inst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    modport slave (
        input  fetch_valid, fetch_pc, mem_done, mem_data,
        output hit, hit_inst, mem_valid, mem_addr
    );

    modport master (
        output fetch_valid, fetch_pc, mem_done, mem_data,
        input  hit, hit_inst, mem_valid, mem_addr
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with combinational hit path and a
// word-at-a-time line refill from the memory controller.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS  = ICACHE_INDEX_BITS,
    parameter int OFFSET_BITS = ICACHE_OFFSET_BITS
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    icache_if.slave  bus
);

    localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - 2;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int TAG_LSB  = 2 + OFFSET_BITS + INDEX_BITS;

    localparam logic [OFFSET_BITS-1:0] CNT_LAST = OFFSET_BITS'(WORDS - 1);

    icache_state_e state_q, state_d;

    logic [LINES-1:0]                  valid_q;
    logic [TAG_BITS-1:0]               tag_arr  [LINES];
    logic [WORDS-1:0][31:0]            data_arr [LINES];

    logic [TAG_BITS-1:0]               miss_tag_q;
    logic [INDEX_BITS-1:0]             miss_idx_q;
    logic [OFFSET_BITS-1:0]            cnt_q;
    logic                              mem_valid_q;
    logic [31:0]                       mem_addr_q;

    logic [TAG_BITS-1:0]               pc_tag;
    logic [INDEX_BITS-1:0]             pc_idx;
    logic [OFFSET_BITS-1:0]            pc_off;
    logic                              lookup_hit;
    logic                              start_refill;
    logic                              word_wr;
    logic                              line_done;
    logic                              unused_pc_lsb;

    assign pc_tag        = bus.fetch_pc[31:TAG_LSB];
    assign pc_idx        = bus.fetch_pc[TAG_LSB-1:2+OFFSET_BITS];
    assign pc_off        = bus.fetch_pc[2+OFFSET_BITS-1:2];
    assign unused_pc_lsb = ^bus.fetch_pc[1:0];

    // A line under refill has its valid bit cleared, and lookups are blocked
    // outside IDLE, so a half-written line can never be observed.
    assign lookup_hit = bus.fetch_valid && valid_q[pc_idx]
                     && (tag_arr[pc_idx] == pc_tag) && (state_q == ICACHE_IDLE);

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;

    always_ff @(posedge clk_in) begin
        if (rst_in)
            state_q <= ICACHE_IDLE;
        else if (rdy_in)
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ICACHE_IDLE:   if (bus.fetch_valid && !lookup_hit) state_d = ICACHE_REFILL;
            ICACHE_REFILL: if (bus.mem_done && cnt_q == CNT_LAST) state_d = ICACHE_IDLE;
            default:       state_d = ICACHE_IDLE;
        endcase
    end

    always_comb begin
        start_refill = 1'b0;
        word_wr      = 1'b0;
        line_done    = 1'b0;
        bus.hit      = lookup_hit;
        bus.hit_inst = lookup_hit ? data_arr[pc_idx][pc_off] : 32'd0;
        case (state_q)
            ICACHE_IDLE: start_refill = bus.fetch_valid && !lookup_hit;
            ICACHE_REFILL: begin
                word_wr   = bus.mem_done;
                line_done = bus.mem_done && (cnt_q == CNT_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q     <= '0;
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
        end else if (rdy_in) begin
            if (start_refill) begin
                valid_q[pc_idx] <= 1'b0;
                cnt_q           <= '0;
                mem_valid_q     <= 1'b1;
                mem_addr_q      <= {pc_tag, pc_idx, {(OFFSET_BITS + 2){1'b0}}};
            end else if (line_done) begin
                valid_q[miss_idx_q] <= 1'b1;
                mem_valid_q         <= 1'b0;
            end else if (word_wr) begin
                // Held mem_valid with a new address is a fresh request.
                cnt_q      <= cnt_q + 1'b1;
                mem_addr_q <= mem_addr_q + 32'd4;
            end
        end
    end

    // Tag/data storage and the miss latch carry no reset; valid bits gate them.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in) begin
            if (start_refill) begin
                miss_tag_q <= pc_tag;
                miss_idx_q <= pc_idx;
            end
            if (word_wr)
                data_arr[miss_idx_q][cnt_q] <= bus.mem_data;
            if (line_done)
                tag_arr[miss_idx_q] <= miss_tag_q;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: memory words are hand-driven by the bench and
// hits are compared against hand-computed instruction words.
module tb_icache;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    icache_if bus();

    icache dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Line 0x0 carries 0x11,0x22,0x33,0x44; every other word is 0xC0DE0000|addr.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h10) return 32'h11 * ((a >> 2) + 1);
        return 32'hC0DE_0000 | a;
    endfunction

    // Called at a negedge: set the request, confirm a miss, step into REFILL.
    task automatic start_miss(input logic [31:0] pc);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = pc;
        #1;
        chk("miss_hit", bus.hit, 1'b0);
        @(negedge clk_in);
    endtask

    task automatic mem_words(input logic [31:0] base, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            chk("mem_valid", bus.mem_valid, 1'b1);
            chk("mem_addr", bus.mem_addr, base + 32'(4 * i));
            bus.mem_done = 1'b1;
            bus.mem_data = mem_word(base + 32'(4 * i));
            @(negedge clk_in);
            bus.mem_done = 1'b0;
            bus.mem_data = 32'hDEAD_BEEF;
        end
    endtask

    task automatic expect_hit(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = pc;
        #1;
        chk({tag, "_hit"}, bus.hit, 1'b1);
        chk({tag, "_inst"}, bus.hit_inst, inst);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in          = 1'b1;
        rdy_in          = 1'b1;
        bus.fetch_valid = 1'b0;
        bus.fetch_pc    = 32'h0;
        bus.mem_done    = 1'b0;
        bus.mem_data    = 32'h0;
        repeat (2) @(negedge clk_in);
        chk("rst_mem_valid", bus.mem_valid, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        rst_in = 1'b0;

        // 1: cold miss on 0x4, refill line 0, then hit word 1
        start_miss(32'h4);
        mem_words(32'h0, 0, 4);
        chk("t1_valid_drop", bus.mem_valid, 1'b0);
        expect_hit("t1", 32'h4, 32'h22);
        @(negedge clk_in);
        expect_hit("t1_stall", 32'h4, 32'h22);

        // 2: warm hit, no memory traffic
        expect_hit("t2", 32'hC, 32'h44);
        @(negedge clk_in);
        chk("t2_no_mem", bus.mem_valid, 1'b0);

        // 3: tag conflict on index 0 replaces the line
        start_miss(32'h400);
        mem_words(32'h400, 0, 4);
        expect_hit("t3", 32'h400, 32'hC0DE_0400);
        start_miss(32'h0);
        mem_words(32'h0, 0, 4);
        expect_hit("t3_back", 32'h0, 32'h11);

        // 4: flush during refill; refill completes, new request follows
        start_miss(32'h100);
        mem_words(32'h100, 0, 1);
        bus.fetch_valid = 1'b0;
        mem_words(32'h100, 1, 1);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h200;
        #1;
        chk("t4_refill_nohit", bus.hit, 1'b0);
        mem_words(32'h100, 2, 2);
        chk("t4_idle_miss", bus.hit, 1'b0);
        chk("t4_idle_mv", bus.mem_valid, 1'b0);
        @(negedge clk_in);
        mem_words(32'h200, 0, 4);
        expect_hit("t4_new", 32'h208, 32'hC0DE_0208);
        expect_hit("t4_old", 32'h104, 32'hC0DE_0104);

        // 5: rdy_in low for 3 cycles swallows a mem_done
        start_miss(32'h300);
        mem_words(32'h300, 0, 1);
        rdy_in = 1'b0;
        @(negedge clk_in);
        bus.mem_done = 1'b1;
        bus.mem_data = 32'hBAD0_BAD0;
        @(negedge clk_in);
        bus.mem_done = 1'b0;
        @(negedge clk_in);
        chk("t5_hold_addr", bus.mem_addr, 32'h304);
        rdy_in = 1'b1;
        mem_words(32'h300, 1, 3);
        expect_hit("t5_w1", 32'h304, 32'hC0DE_0304);

        // mem_done in IDLE changes nothing
        bus.mem_done = 1'b1;
        @(negedge clk_in);
        bus.mem_done = 1'b0;
        chk("idle_done_mv", bus.mem_valid, 1'b0);
        expect_hit("idle_done", 32'h300, 32'hC0DE_0300);

        // 6: reset after two words, then line 0 refills from word 0
        start_miss(32'h500);
        mem_words(32'h500, 0, 2);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("t6_rst_mv", bus.mem_valid, 1'b0);
        chk("t6_rst_ma", bus.mem_addr, 32'h0);
        rst_in = 1'b0;
        start_miss(32'h0);
        mem_words(32'h0, 0, 4);
        expect_hit("t6", 32'h8, 32'h33);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
